swiglu_mul_ctrl: RTL and testbench

- Downstream of the SiLU controller in the FFN path. Computes the SwiGLU gate product silu(G) ⊙ U for one 64-element tile.
- Latches the SiLU buffer and the U_proj tile on a start pulse. Time-multiplexes the shared 8-lane FMA array in multiply mode, one 8-element group per cycle.
- Collects results into a 64-element output buffer, which is presented to the down-projection stage with a valid/ready handshake.

---
 rtl/swiglu_mul_ctrl_if.sv | 34 +++
 rtl/swiglu_mul_ctrl.sv | 152 +++++++++++++++
 tb/tb_swiglu_mul_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swiglu_mul_ctrl_if.sv
// Bundle of the SwiGLU multiply controller's start, operand, FMA and
// output-handshake signals. The slave modport is the controller's view;
// the master modport is the view of whatever surrounds it.
`timescale 1ns/1ps

interface swiglu_mul_ctrl_if #(
  parameter int BW_FP    = 17,
  parameter int VALUE_MN = 64
) ();

  logic                      start_mul;
  logic [VALUE_MN*BW_FP-1:0] silu_in;
  logic [VALUE_MN*BW_FP-1:0] u_proj;
  logic [8*BW_FP-1:0]        FMA_out;
  logic                      busy_mul;
  logic [8*5-1:0]            mode_mul;
  logic [8*BW_FP-1:0]        a_mul;
  logic [8*BW_FP-1:0]        b_mul;
  logic [8*BW_FP-1:0]        c_mul;
  logic [VALUE_MN*BW_FP-1:0] mul_out;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  start_mul, silu_in, u_proj, FMA_out, out_ready,
    output busy_mul, mode_mul, a_mul, b_mul, c_mul, mul_out, out_valid
  );

  modport master (
    output start_mul, silu_in, u_proj, FMA_out, out_ready,
    input  busy_mul, mode_mul, a_mul, b_mul, c_mul, mul_out, out_valid
  );

endinterface

// File: rtl/swiglu_mul_ctrl.sv
// SwiGLU gate product controller: latches a 64-element SiLU tile and U tile,
// streams them through the shared 8-lane FMA array in multiply mode one
// group per cycle, gathers the products and offers them downstream with a
// valid/ready handshake. No arithmetic happens here.
`timescale 1ns/1ps

module swiglu_mul_ctrl #(
  parameter int               BW_FP    = 17,
  parameter int               VALUE_MN = 64,
  parameter int               FMA_LAT  = 2,
  parameter logic [4:0]       MODE_FMA = 5'b00100,
  parameter logic [BW_FP-1:0] FP_ZERO  = 17'h0
) (
  input  logic             clk,
  input  logic             rst,
  swiglu_mul_ctrl_if.slave bus
);

  // The tile is always 8 groups of 8 lanes; VALUE_MN only sets the packing.
  localparam int LANES   = 8;
  localparam int GROUPS  = 8;
  localparam int GROUP_W = LANES * BW_FP;
  localparam int TILE_W  = VALUE_MN * BW_FP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               g_q, g_d;
  logic [TILE_W-1:0]        silu_q, silu_d;
  logic [TILE_W-1:0]        u_q, u_d;
  logic [TILE_W-1:0]        mul_out_q, mul_out_d;
  logic [FMA_LAT-1:0]       pipe_v_q, pipe_v_d;
  logic [FMA_LAT-1:0][2:0]  pipe_g_q, pipe_g_d;

  logic                     issuing;
  logic                     cap_v;
  logic [2:0]               cap_g;
  logic [8*5-1:0]           mode_mul;
  logic [GROUP_W-1:0]       a_mul;
  logic [GROUP_W-1:0]       b_mul;
  logic [GROUP_W-1:0]       c_mul;

  assign issuing = (state_q == ISSUE);
  assign cap_v   = pipe_v_q[FMA_LAT-1];
  assign cap_g   = pipe_g_q[FMA_LAT-1];

  // Next-state logic; operands are latched only when a start is taken in IDLE.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    silu_d  = silu_q;
    u_d     = u_q;
    case (state_q)
      IDLE: begin
        if (bus.start_mul) begin
          state_d = ISSUE;
          g_d     = 3'd0;
          silu_d  = bus.silu_in;
          u_d     = bus.u_proj;
        end
      end
      ISSUE: begin
        g_d = g_q + 3'd1;
        if (g_q == 3'd7) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cap_v && (cap_g == 3'd7)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline mirroring the FMA latency, and the product buffer write-back.
  always_comb begin
    pipe_v_d    = pipe_v_q;
    pipe_g_d    = pipe_g_q;
    pipe_v_d[0] = issuing;
    pipe_g_d[0] = g_q;
    for (int i = 1; i < FMA_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_g_d[i] = pipe_g_q[i-1];
    end
    mul_out_d = mul_out_q;
    for (int k = 0; k < GROUPS; k++) begin
      if (cap_v && (cap_g == 3'(k))) begin
        mul_out_d[k*GROUP_W +: GROUP_W] = bus.FMA_out;
      end
    end
  end

  // FMA drive: multiply mode with a zero addend while issuing, all zero otherwise.
  always_comb begin
    mode_mul = '0;
    a_mul    = '0;
    b_mul    = '0;
    c_mul    = '0;
    if (issuing) begin
      mode_mul = {LANES{MODE_FMA}};
      c_mul    = {LANES{FP_ZERO}};
      for (int k = 0; k < GROUPS; k++) begin
        if (g_q == 3'(k)) begin
          a_mul = silu_q[k*GROUP_W +: GROUP_W];
          b_mul = u_q[k*GROUP_W +: GROUP_W];
        end
      end
    end
  end

  // State, operand and result registers; reset aborts any run in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= 3'd0;
      silu_q    <= '0;
      u_q       <= '0;
      mul_out_q <= '0;
      pipe_v_q  <= '0;
      pipe_g_q  <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      silu_q    <= silu_d;
      u_q       <= u_d;
      mul_out_q <= mul_out_d;
      pipe_v_q  <= pipe_v_d;
      pipe_g_q  <= pipe_g_d;
    end
  end

  assign bus.busy_mul  = (state_q != IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.mul_out   = mul_out_q;
  assign bus.mode_mul  = mode_mul;
  assign bus.a_mul     = a_mul;
  assign bus.b_mul     = b_mul;
  assign bus.c_mul     = c_mul;

endmodule

// File: tb/tb_swiglu_mul_ctrl.sv
// Scoreboard bench for swiglu_mul_ctrl: directed tiles, an FMA stub that
// returns operand b after FMA_LAT cycles, expected issues and results queued
// at start and checked by an independent monitor.
`timescale 1ns/1ps

module tb_swiglu_mul_ctrl;

  localparam int         BW_FP    = 17;
  localparam int         VALUE_MN = 64;
  localparam int         FMA_LAT  = 2;
  localparam logic [4:0] MODE_FMA = 5'b00100;
  localparam int         GROUP_W  = 8 * BW_FP;
  localparam int         TILE_W   = VALUE_MN * BW_FP;

  typedef struct {
    int                 g;
    logic [GROUP_W-1:0] a;
    logic [GROUP_W-1:0] b;
  } issue_t;

  logic clk;
  logic rst;
  int   cyc;
  int   t_start;
  int   total;
  int   bad;
  int   issue_cnt;
  int   hs_cnt;

  issue_t            issue_q[$];
  logic [TILE_W-1:0] result_q[$];

  logic [FMA_LAT-1:0][GROUP_W-1:0] fma_pipe;

  swiglu_mul_ctrl_if #(.BW_FP(BW_FP), .VALUE_MN(VALUE_MN)) bus ();

  swiglu_mul_ctrl #(
    .BW_FP   (BW_FP),
    .VALUE_MN(VALUE_MN),
    .FMA_LAT (FMA_LAT),
    .MODE_FMA(MODE_FMA),
    .FP_ZERO (17'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time issues and out_valid relative to the start edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FMA stub: result is operand b delayed by FMA_LAT registers.
  always @(posedge clk) begin
    fma_pipe[0] <= bus.b_mul;
    for (int i = 1; i < FMA_LAT; i++) fma_pipe[i] <= fma_pipe[i-1];
  end
  assign bus.FMA_out = fma_pipe[FMA_LAT-1];

  task automatic check_output(input string name, input logic [GROUP_W-1:0] actual,
                              input logic [GROUP_W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_tile(input string name, input logic [TILE_W-1:0] actual,
                            input logic [TILE_W-1:0] expected);
    int first;
    total++;
    if (actual !== expected) begin
      bad++;
      first = -1;
      for (int i = VALUE_MN - 1; i >= 0; i--)
        if (actual[i*BW_FP +: BW_FP] !== expected[i*BW_FP +: BW_FP]) first = i;
      $display("[TB] FAIL %s: element %0d got %h expected %h (t=%0t)", name, first,
               actual[first*BW_FP +: BW_FP], expected[first*BW_FP +: BW_FP], $time);
    end
  endtask

  function automatic logic [TILE_W-1:0] make_tile(input int base, input int step);
    logic [TILE_W-1:0] t;
    int v;
    t = '0;
    for (int i = 0; i < VALUE_MN; i++) begin
      v = base + i * step;
      t[i*BW_FP +: BW_FP] = v[BW_FP-1:0];
    end
    return t;
  endfunction

  // Monitor: checks every issue and every completed handshake against the queues.
  always @(negedge clk) begin
    issue_t exp_i;
    if (bus.mode_mul != '0) begin
      issue_cnt++;
      if (issue_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_issue: got a=%h expected no issue (t=%0t)", bus.a_mul, $time);
      end else begin
        exp_i = issue_q.pop_front();
        check_output("issue_a", bus.a_mul, exp_i.a);
        check_output("issue_b", bus.b_mul, exp_i.b);
        check_output("issue_c", bus.c_mul, '0);
        check_output("issue_mode", GROUP_W'(bus.mode_mul), GROUP_W'({8{MODE_FMA}}));
        check_int("issue_cycle", cyc - t_start, exp_i.g);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      if (result_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_handshake: got handshake expected none (t=%0t)", $time);
      end else begin
        check_tile("result", bus.mul_out, result_q.pop_front());
      end
    end
  end

  // Pulse start with the given tiles and queue what the DUT must produce.
  task automatic apply_stimulus(input logic [TILE_W-1:0] silu, input logic [TILE_W-1:0] u);
    issue_t e;
    bus.silu_in   = silu;
    bus.u_proj    = u;
    bus.start_mul = 1'b1;
    for (int g = 0; g < 8; g++) begin
      e.g = g;
      e.a = silu[g*GROUP_W +: GROUP_W];
      e.b = u[g*GROUP_W +: GROUP_W];
      issue_q.push_back(e);
    end
    result_q.push_back(u);
    @(posedge clk);
    #1;
    bus.start_mul = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 200);
    check_int({name, "_valid_latency"}, cyc - t_start, 8 + FMA_LAT);
  endtask

  task automatic do_handshake(input string name, input logic [TILE_W-1:0] u, input logic start_too);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.start_mul = start_too;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.start_mul = 1'b0;
    check_int({name, "_valid_after_hs"}, int'(bus.out_valid), 0);
    check_int({name, "_busy_after_hs"}, int'(bus.busy_mul), 0);
    check_tile({name, "_retained"}, bus.mul_out, u);
  endtask

  task automatic check_all_zero(input string name);
    check_int({name, "_busy"}, int'(bus.busy_mul), 0);
    check_int({name, "_valid"}, int'(bus.out_valid), 0);
    check_tile({name, "_mul_out"}, bus.mul_out, '0);
    check_output({name, "_mode"}, GROUP_W'(bus.mode_mul), '0);
    check_output({name, "_a"}, bus.a_mul, '0);
    check_output({name, "_b"}, bus.b_mul, '0);
    check_output({name, "_c"}, bus.c_mul, '0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [TILE_W-1:0] u1, s1, u2, s2, u3, s3, u4, s4, u5, s5;
    int bp_err;
    total = 0; bad = 0; issue_cnt = 0; hs_cnt = 0; t_start = 0;
    rst = 1'b1;
    bus.start_mul = 1'b0;
    bus.out_ready = 1'b0;
    bus.silu_in   = '0;
    bus.u_proj    = '0;

    u1 = make_tile(0, 1);          s1 = make_tile(32'h100, 1);
    u2 = make_tile(32'h10005, 32'h101); s2 = make_tile(32'h0AA00, 7);
    u3 = make_tile(32'h0F000, 32'h211); s3 = make_tile(32'h12345, 32'h35);
    u4 = make_tile(32'h0C0DE, 3);  s4 = make_tile(32'h01111, 9);
    u5 = make_tile(32'h1FF00, 1);  s5 = make_tile(32'h1FFFF, -1);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] mapping run");
    apply_stimulus(s1, u1);
    wait_valid("map");
    do_handshake("map", u1, 1'b0);

    $display("[TB] operand latch and backpressure run");
    apply_stimulus(s2, u2);
    bus.silu_in = '1;
    bus.u_proj  = '1;
    wait_valid("latch");
    bp_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.busy_mul !== 1'b1 || bus.mul_out !== u2) bp_err++;
    end
    check_int("backpressure_hold_errors", bp_err, 0);
    do_handshake("latch", u2, 1'b0);

    $display("[TB] ignored start run");
    issue_cnt = 0;
    hs_cnt    = 0;
    apply_stimulus(s3, u3);
    repeat (3) @(posedge clk);
    #1;
    bus.start_mul = 1'b1;
    @(posedge clk);
    #1;
    bus.start_mul = 1'b0;
    wait_valid("ignore");
    @(posedge clk);
    #1;
    bus.start_mul = 1'b1;
    @(posedge clk);
    #1;
    bus.start_mul = 1'b0;
    do_handshake("ignore", u3, 1'b1);
    repeat (20) @(negedge clk);
    check_int("ignore_busy_idle", int'(bus.busy_mul), 0);
    check_int("ignore_issue_count", issue_cnt, 8);
    check_int("ignore_handshake_count", hs_cnt, 1);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-run");
    apply_stimulus(s4, u4);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    issue_q.delete();
    result_q.delete();
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(s5, u5);
    wait_valid("after_rst");
    do_handshake("after_rst", u5, 1'b0);

    repeat (3) @(posedge clk);
    check_int("queues_drained", issue_q.size() + result_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
